// File: rtl/fsm_pkg.sv
// Shared types and width helper for the counter/checker FSM family.
package fsm_pkg;

    // Lock-tracking state shared by period checkers.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Bits needed to hold the values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/interval_counter.sv
// Saturating cycles-since-last-event counter: loads 1 on an event,
// otherwise counts up to MAX and sticks there; freezes while en is low.
module interval_counter
    import fsm_pkg::*;
#(
    parameter int MAX = 3,
    parameter int W   = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    output logic [W-1:0] cyc
);

    // Load-to-1 has priority over counting; saturation keeps a long gap at MAX.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc <= '0;
        end else if (en) begin
            if (load) begin
                cyc <= W'(1);
            end else if (cyc != W'(MAX)) begin
                cyc <= cyc + W'(1);
            end
        end
    end

endmodule

// File: rtl/pulse_period_checker.sv
// Monitors a periodic single-cycle pulse stream, locks after LOCK_CNT
// correct intervals, and reports missing/early pulses while locked.
// Every decision is taken only on en=1 cycles; en=0 cycles are invisible.
module pulse_period_checker
    import fsm_pkg::*;
#(
    parameter int PERIOD   = 3,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pulse_in,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_missing,
    output logic             err_early,
    output logic [ERR_W-1:0] err_count
);

    localparam int CW = cnt_width(PERIOD);
    localparam int GW = cnt_width(LOCK_CNT);

    state_t         state;
    state_t         next_state;
    logic [CW-1:0]  cyc;
    logic [GW-1:0]  good;
    logic [GW-1:0]  good_nxt;
    logic [GW-1:0]  good_inc;
    logic           cyc_full;
    logic           ev_early;
    logic           ev_missing;

    // Every pulse seen with en=1 restarts the interval, whatever the state.
    interval_counter #(
        .MAX (PERIOD),
        .W   (CW)
    ) u_interval (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .load  (pulse_in),
        .cyc   (cyc)
    );

    assign cyc_full = (cyc == CW'(PERIOD));
    assign good_inc = good + GW'(1);

    // Next state, good-interval count and error events from the current cycle.
    always_comb begin
        next_state = state;
        good_nxt   = good;
        ev_early   = 1'b0;
        ev_missing = 1'b0;
        case (state)
            HUNT: begin
                if (pulse_in) begin
                    next_state = VERIFY;
                    good_nxt   = '0;
                end
            end
            VERIFY: begin
                if (pulse_in) begin
                    if (cyc_full) begin
                        if (good_inc == GW'(LOCK_CNT)) begin
                            next_state = LOCKED;
                            good_nxt   = '0;
                        end else begin
                            good_nxt = good_inc;
                        end
                    end else begin
                        // Early pulse: restart verification from this pulse.
                        good_nxt = '0;
                    end
                end else if (cyc_full) begin
                    next_state = HUNT;
                    good_nxt   = '0;
                end
            end
            LOCKED: begin
                if (pulse_in) begin
                    if (!cyc_full) begin
                        next_state = VERIFY;
                        good_nxt   = '0;
                        ev_early   = 1'b1;
                    end
                end else if (cyc_full) begin
                    next_state = HUNT;
                    ev_missing = 1'b1;
                end
            end
            default: begin
                next_state = HUNT;
                good_nxt   = '0;
            end
        endcase
    end

    // State and good counter advance only on enabled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT;
            good  <= '0;
        end else if (en) begin
            state <= next_state;
            good  <= good_nxt;
        end
    end

    // Registered status: strobes last one enabled cycle, counter saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_missing <= 1'b0;
            err_early   <= 1'b0;
            err_count   <= '0;
        end else if (en) begin
            locked      <= (next_state == LOCKED);
            err_pulse   <= ev_early | ev_missing;
            err_missing <= ev_missing;
            err_early   <= ev_early;
            if ((ev_early || ev_missing) && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pulse_period_checker.sv
// Directed bench for pulse_period_checker. Three instances share stimulus:
// u_main (PERIOD=3, LOCK_CNT=2, ERR_W=8), u_sat (ERR_W=2) and
// u_p2 (PERIOD=2, LOCK_CNT=1). "Cycle c" is the c-th step after reset;
// outputs sampled after step c are the values seen during cycle c+1.
module tb_pulse_period_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en;
    logic       pulse_in;

    logic       m_locked, m_err_pulse, m_err_missing, m_err_early;
    logic [7:0] m_err_count;
    logic       s_locked, s_err_pulse, s_err_missing, s_err_early;
    logic [1:0] s_err_count;
    logic       p_locked, p_err_pulse, p_err_missing, p_err_early;
    logic [7:0] p_err_count;

    int checks   = 0;
    int failures = 0;

    pulse_period_checker #(.PERIOD(3), .LOCK_CNT(2), .ERR_W(8)) u_main (
        .clk(clk), .reset(reset), .en(en), .pulse_in(pulse_in),
        .locked(m_locked), .err_pulse(m_err_pulse), .err_missing(m_err_missing),
        .err_early(m_err_early), .err_count(m_err_count)
    );

    pulse_period_checker #(.PERIOD(3), .LOCK_CNT(2), .ERR_W(2)) u_sat (
        .clk(clk), .reset(reset), .en(en), .pulse_in(pulse_in),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_missing(s_err_missing),
        .err_early(s_err_early), .err_count(s_err_count)
    );

    pulse_period_checker #(.PERIOD(2), .LOCK_CNT(1), .ERR_W(8)) u_p2 (
        .clk(clk), .reset(reset), .en(en), .pulse_in(pulse_in),
        .locked(p_locked), .err_pulse(p_err_pulse), .err_missing(p_err_missing),
        .err_early(p_err_early), .err_count(p_err_count)
    );

    // Apply one cycle of stimulus, then sample just after the edge.
    task automatic step(input logic p, input logic e);
        pulse_in = p;
        en       = e;
        @(posedge clk);
        #1;
    endtask

    // Reset is asserted with en=0 so reset priority over en is exercised.
    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Drive some activity first so the reset has state to clear.
        reset = 1'b0;
        for (int c = 0; c < 8; c++) step(c % 3 == 0, 1'b1);
        do_reset();
        checks++;
        if ({m_locked, m_err_pulse, m_err_missing, m_err_early} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_main_flags got=%b exp=0000",
                     {m_locked, m_err_pulse, m_err_missing, m_err_early});
        end
        checks++;
        if (m_err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_main_count got=%0d exp=0", m_err_count);
        end
        checks++;
        if ({s_locked, s_err_pulse, s_err_missing, s_err_early, s_err_count} !== 6'b0) begin
            failures++;
            $display("FAIL reset_sat got=%b exp=000000",
                     {s_locked, s_err_pulse, s_err_missing, s_err_early, s_err_count});
        end
        checks++;
        if ({p_locked, p_err_pulse, p_err_missing, p_err_early} !== 4'b0000 || p_err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_p2 flags=%b count=%0d exp=0",
                     {p_locked, p_err_pulse, p_err_missing, p_err_early}, p_err_count);
        end
    endtask

    // Pulses at 0,3,6,9 lock from cycle 7; then 12 is omitted.
    task automatic test_lock_and_missing();
        logic exp_lock;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(c % 3 == 0, 1'b1);
            exp_lock = (c >= 6);
            checks++;
            if (m_locked !== exp_lock || m_err_pulse !== 1'b0) begin
                failures++;
                $display("FAIL lock c=%0d locked=%b err=%b exp_locked=%b exp_err=0",
                         c, m_locked, m_err_pulse, exp_lock);
            end
        end
        step(1'b0, 1'b1);  // cycle 12: expected pulse absent
        checks++;
        if ({m_err_pulse, m_err_missing, m_err_early, m_locked} !== 4'b1100) begin
            failures++;
            $display("FAIL missing_flags got=%b exp=1100",
                     {m_err_pulse, m_err_missing, m_err_early, m_locked});
        end
        checks++;
        if (m_err_count !== 8'd1) begin
            failures++;
            $display("FAIL missing_count got=%0d exp=1", m_err_count);
        end
        // Strobe holds across an en=0 cycle and clears on the next en=1 cycle.
        step(1'b0, 1'b0);
        checks++;
        if (m_err_pulse !== 1'b1 || m_err_missing !== 1'b1 || m_err_count !== 8'd1) begin
            failures++;
            $display("FAIL missing_hold err=%b miss=%b count=%0d exp=1,1,1",
                     m_err_pulse, m_err_missing, m_err_count);
        end
        step(1'b0, 1'b1);
        checks++;
        if ({m_err_pulse, m_err_missing, m_err_early} !== 3'b000) begin
            failures++;
            $display("FAIL missing_clear got=%b exp=000", {m_err_pulse, m_err_missing, m_err_early});
        end
        // Back in HUNT: needs an acquiring pulse plus two correct intervals.
        for (int c = 0; c < 7; c++) begin
            step(c % 3 == 0, 1'b1);
            exp_lock = (c == 6);
            checks++;
            if (m_locked !== exp_lock) begin
                failures++;
                $display("FAIL relock_hunt c=%0d locked=%b exp=%b", c, m_locked, exp_lock);
            end
        end
    endtask

    // Early pulse at cycle 11 while locked, then relock via 14 and 17.
    task automatic test_early();
        do_reset();
        for (int c = 0; c < 11; c++) step(c % 3 == 0, 1'b1);
        step(1'b1, 1'b1);  // cycle 11, cyc==2
        checks++;
        if ({m_err_pulse, m_err_missing, m_err_early, m_locked} !== 4'b1010) begin
            failures++;
            $display("FAIL early_flags got=%b exp=1010",
                     {m_err_pulse, m_err_missing, m_err_early, m_locked});
        end
        checks++;
        if (m_err_count !== 8'd1) begin
            failures++;
            $display("FAIL early_count got=%0d exp=1", m_err_count);
        end
        for (int c = 12; c < 18; c++) begin
            step(c == 14 || c == 17, 1'b1);
            checks++;
            if (m_locked !== (c == 17) || m_err_pulse !== 1'b0) begin
                failures++;
                $display("FAIL early_relock c=%0d locked=%b err=%b exp_locked=%b exp_err=0",
                         c, m_locked, m_err_pulse, (c == 17));
            end
        end
        checks++;
        if (m_err_count !== 8'd1) begin
            failures++;
            $display("FAIL early_count_after got=%0d exp=1", m_err_count);
        end
    endtask

    // en low for cycles 4-5 (with a stray pulse at 5); pulses 0,3,8,11.
    task automatic test_enable();
        logic p;
        logic e;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            p = (c inside {0, 3, 5, 8, 11});
            e = !(c inside {4, 5});
            step(p, e);
            checks++;
            if (m_locked !== (c >= 8) || m_err_pulse !== 1'b0) begin
                failures++;
                $display("FAIL enable c=%0d locked=%b err=%b exp_locked=%b exp_err=0",
                         c, m_locked, m_err_pulse, (c >= 8));
            end
        end
        checks++;
        if (m_err_count !== 8'd0) begin
            failures++;
            $display("FAIL enable_count got=%0d exp=0", m_err_count);
        end
    endtask

    // ERR_W=2: four lock/miss rounds give 1,2,3,3; then reset mid-LOCKED.
    task automatic test_saturate();
        logic [1:0] exp_cnt;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 9; c++) step(c % 3 == 0, 1'b1);
            checks++;
            if (s_locked !== 1'b1) begin
                failures++;
                $display("FAIL sat_locked r=%0d got=%b exp=1", r, s_locked);
            end
            step(1'b0, 1'b1);  // missing pulse
            exp_cnt = (r >= 2) ? 2'd3 : 2'(r + 1);
            checks++;
            if ({s_err_pulse, s_err_missing, s_err_early, s_locked} !== 4'b1100 || s_err_count !== exp_cnt) begin
                failures++;
                $display("FAIL sat_round r=%0d flags=%b count=%0d exp_flags=1100 exp_count=%0d",
                         r, {s_err_pulse, s_err_missing, s_err_early, s_locked}, s_err_count, exp_cnt);
            end
        end
        for (int c = 0; c < 7; c++) step(c % 3 == 0, 1'b1);
        checks++;
        if (s_locked !== 1'b1) begin
            failures++;
            $display("FAIL sat_prereset_locked got=%b exp=1", s_locked);
        end
        reset = 1'b1;
        step(1'b1, 1'b1);
        reset = 1'b0;
        checks++;
        if ({s_locked, s_err_pulse, s_err_missing, s_err_early, s_err_count} !== 6'b0) begin
            failures++;
            $display("FAIL sat_reset got=%b exp=000000",
                     {s_locked, s_err_pulse, s_err_missing, s_err_early, s_err_count});
        end
    endtask

    // PERIOD=2, LOCK_CNT=1: pulses every cycle never lock; every 2 cycles locks.
    task automatic test_period2();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 1'b1);
            checks++;
            if (p_locked !== 1'b0 || p_err_pulse !== 1'b0) begin
                failures++;
                $display("FAIL p2_every c=%0d locked=%b err=%b exp=0,0", c, p_locked, p_err_pulse);
            end
        end
        step(1'b0, 1'b1);
        checks++;
        if (p_locked !== 1'b0) begin
            failures++;
            $display("FAIL p2_gap locked=%b exp=0", p_locked);
        end
        step(1'b1, 1'b1);
        checks++;
        if (p_locked !== 1'b1 || p_err_pulse !== 1'b0) begin
            failures++;
            $display("FAIL p2_lock locked=%b err=%b exp=1,0", p_locked, p_err_pulse);
        end
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if (p_locked !== 1'b1 || p_err_pulse !== 1'b0) begin
            failures++;
            $display("FAIL p2_hold locked=%b err=%b exp=1,0", p_locked, p_err_pulse);
        end
        step(1'b1, 1'b1);  // cyc==1 while locked: early
        checks++;
        if ({p_err_pulse, p_err_missing, p_err_early, p_locked} !== 4'b1010 || p_err_count !== 8'd1) begin
            failures++;
            $display("FAIL p2_early flags=%b count=%0d exp_flags=1010 exp_count=1",
                     {p_err_pulse, p_err_missing, p_err_early, p_locked}, p_err_count);
        end
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        pulse_in = 1'b0;
        test_reset();
        test_lock_and_missing();
        test_early();
        test_enable();
        test_saturate();
        test_period2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
